// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus controller and its command sequencer:
// FSM state encoding, default strobe timing and HD44780 command bytes.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ENABLE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } lcd_state_e;

    // Defaults sized for a 50 MHz clock: 16 cycles of EN = 320 ns (>= 230 ns).
    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_EN    = 16;
    localparam int DEF_T_HOLD  = 2;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // HD44780 command bytes used by the sequencer.
    localparam logic [7:0] FUNC_SET_8BIT_2LINE = 8'h38;
    localparam logic [7:0] DISP_ON             = 8'h0C;
    localparam logic [7:0] CLEAR               = 8'h01;
    localparam logic [7:0] ENTRY_INC           = 8'h06;
    localparam logic [7:0] DDRAM_LINE1         = 8'h80;
    localparam logic [7:0] DDRAM_LINE2         = 8'hC0;

    // Terminal count for a phase of n cycles; the counter starts at 0 on entry.
    function automatic logic [CNT_W-1:0] last_count(input int n);
        return (n > 0) ? CNT_W'(n - 1) : '0;
    endfunction

endpackage

// File: rtl/lcd_bus_controller_if.sv
// Start/done handshake between the LCD sequencer (master) and the bus
// controller (slave).
//
// Handshake: the master presents iDATA/iRS and raises iStart, holding it high
// until it has seen oDone, plus one further cycle. The slave accepts only on a
// rising edge of iStart while idle, samples iDATA/iRS on that edge, and pulses
// oDone for exactly one cycle when the LCD write, including hold time, is
// complete. iStart must go low for at least one cycle before the next request.
interface lcd_bus_controller_if;
    import lcd_pkg::*;

    logic [7:0] iDATA;
    logic       iRS;
    logic       iStart;
    logic       oDone;

    modport master (output iDATA, output iRS, output iStart, input oDone);
    modport slave  (input iDATA, input iRS, input iStart, output oDone);

endinterface

// File: rtl/lcd_bus_controller.sv
// Write-only HD44780 bus driver: latches one RS+byte per start request and
// produces a registered LCD_EN strobe with setup and hold time around it.
module lcd_bus_controller
    import lcd_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_EN    = DEF_T_EN,
    parameter int T_HOLD  = DEF_T_HOLD
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    lcd_bus_controller_if.slave  bus,
    output logic [7:0]           LCD_DATA,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic                 LCD_EN,
    output lcd_state_e           state_o
);

    // Timing parameters must fit the single 8-bit phase counter.
    if (T_SETUP < 0 || T_SETUP > CNT_MAX) begin : g_bad_setup
        $error("lcd_bus_controller: T_SETUP must be in 0..255");
    end
    if (T_EN < 1 || T_EN > CNT_MAX) begin : g_bad_en
        $error("lcd_bus_controller: T_EN must be in 1..255");
    end
    if (T_HOLD < 0 || T_HOLD > CNT_MAX) begin : g_bad_hold
        $error("lcd_bus_controller: T_HOLD must be in 0..255");
    end

    localparam logic [CNT_W-1:0] SETUP_LAST = last_count(T_SETUP);
    localparam logic [CNT_W-1:0] EN_LAST    = last_count(T_EN);
    localparam logic [CNT_W-1:0] HOLD_LAST  = last_count(T_HOLD);

    // State entered after the EN phase and after an accept, skipping empty phases.
    localparam lcd_state_e AFTER_ACCEPT = (T_SETUP == 0) ? ENABLE : SETUP;
    localparam lcd_state_e AFTER_EN     = (T_HOLD == 0)  ? DONE   : HOLD;

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic [7:0]       data_q;
    logic             rs_q;
    logic             accept;

    // Only a fresh rising edge of iStart seen while idle starts a transfer.
    assign accept = bus.iStart && !start_q && (state_q == IDLE);

    // State, counter, edge detector and registered strobes.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= bus.iStart;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    // Byte and RS are captured once per accept and held through the whole write.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            data_q <= '0;
            rs_q   <= 1'b0;
        end else if (accept) begin
            data_q <= bus.iDATA;
            rs_q   <= bus.iRS;
        end
    end

    // Next-state logic; the counter restarts from 0 on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = AFTER_ACCEPT;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ENABLE;
                    cnt_d   = '0;
                end
            end
            ENABLE: begin
                if (cnt_q == EN_LAST) begin
                    state_d = AFTER_EN;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Strobes are decoded from the next state so they register glitch-free
        // and line up exactly with the ENABLE and DONE states.
        en_d   = (state_d == ENABLE);
        done_d = (state_d == DONE);
    end

    assign LCD_DATA  = data_q;
    assign LCD_RS    = rs_q;
    assign LCD_RW    = 1'b0;
    assign LCD_EN    = en_q;
    assign bus.oDone = done_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_lcd_bus_controller.sv
// Bench for lcd_bus_controller: a default-timing instance and a minimum-timing
// instance (T_SETUP=0, T_EN=1, T_HOLD=0), with a scoreboard of expected
// RS+byte values checked on every LCD_EN rising edge.
module tb_lcd_bus_controller;
    import lcd_pkg::*;

    localparam int TS[2] = '{2, 0};
    localparam int TE[2] = '{16, 1};
    localparam int TH[2] = '{2, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_bus_controller_if bus0 ();
    lcd_bus_controller_if bus1 ();

    logic [1:0] en_w, rs_w, rw_w, done_w;
    logic [7:0] data_w[2];
    lcd_state_e st_w[2];

    assign done_w[0] = bus0.oDone;
    assign done_w[1] = bus1.oDone;

    lcd_bus_controller #(.T_SETUP(TS[0]), .T_EN(TE[0]), .T_HOLD(TH[0])) dut0 (
        .iCLK(clk), .iRST_N(rst_n), .bus(bus0),
        .LCD_DATA(data_w[0]), .LCD_RS(rs_w[0]), .LCD_RW(rw_w[0]),
        .LCD_EN(en_w[0]), .state_o(st_w[0])
    );

    lcd_bus_controller #(.T_SETUP(TS[1]), .T_EN(TE[1]), .T_HOLD(TH[1])) dut1 (
        .iCLK(clk), .iRST_N(rst_n), .bus(bus1),
        .LCD_DATA(data_w[1]), .LCD_RS(rs_w[1]), .LCD_RW(rw_w[1]),
        .LCD_EN(en_w[1]), .state_o(st_w[1])
    );

    // Scoreboard and monitor state
    logic [8:0] exp_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int done_cnt[2] = '{0, 0};
    int pulses[2] = '{0, 0};
    int drive_cyc[2] = '{0, 0};
    int width[2] = '{0, 0};
    logic en_prev[2] = '{1'b0, 1'b0};
    logic [8:0] cap[2] = '{9'h0, 9'h0};
    logic stable[2] = '{1'b1, 1'b1};
    int rw_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: on EN rise pop and compare; on EN fall check width and stability.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rw_w != 2'b00) rw_bad <= rw_bad + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                en_prev[i] <= 1'b0;
                width[i]   <= 0;
            end else begin
                en_prev[i] <= en_w[i];
                if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
                if (en_w[i] && !en_prev[i]) begin
                    pulses[i] <= pulses[i] + 1;
                    width[i]  <= 1;
                    cap[i]    <= {rs_w[i], data_w[i]};
                    stable[i] <= 1'b1;
                    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("en_bus", 32'({rs_w[i], data_w[i]}), 32'(e));
                    end
                    chk("en_rise_lat", 32'(cyc - drive_cyc[i]), 32'(1 + TS[i]));
                end else if (en_w[i]) begin
                    width[i] <= width[i] + 1;
                    if ({rs_w[i], data_w[i]} != cap[i]) stable[i] <= 1'b0;
                end else if (en_prev[i]) begin
                    chk("en_width", 32'(width[i]), 32'(TE[i]));
                    chk("bus_stable", 32'(stable[i]), 32'd1);
                end
            end
        end
    end

    task automatic set_start(input int d, input logic s);
        if (d == 0) bus0.iStart = s;
        else        bus1.iStart = s;
    endtask

    task automatic start_xfer(input int d, input logic rs, input logic [7:0] data);
        @(negedge clk);
        if (d == 0) begin bus0.iRS = rs; bus0.iDATA = data; end
        else        begin bus1.iRS = rs; bus1.iDATA = data; end
        set_start(d, 1'b1);
        exp_q.push_back({rs, data});
        drive_cyc[d] = cyc;
    endtask

    task automatic wait_done(input int d, output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (done_w[d]) begin
                ok = 1'b1;
                lat = cyc - drive_cyc[d];
            end
        end
    endtask

    // Wait for oDone, check latency and pulse width, then release iStart one
    // cycle later and leave it low for a cycle.
    task automatic finish_xfer(input int d);
        int lat;
        bit ok;
        wait_done(d, lat, ok);
        chk("done_seen", 32'(ok), 32'd1);
        if (ok) chk("done_lat", 32'(lat), 32'(1 + TS[d] + TE[d] + TH[d]));
        @(negedge clk);
        chk("done_one_cycle", 32'(done_w[d]), 32'd0);
        set_start(d, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_xfer(input int d, input logic rs, input logic [7:0] data);
        start_xfer(d, rs, data);
        finish_xfer(d);
    endtask

    task automatic wait_en(input int d, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (en_w[d]) ok = 1'b1;
        end
    endtask

    logic [7:0] init_seq[5] = '{FUNC_SET_8BIT_2LINE, DISP_ON, CLEAR, ENTRY_INC, DDRAM_LINE1};

    initial begin
        int p0, d0;
        bit ok;
        bus0.iStart = 1'b0; bus0.iRS = 1'b0; bus0.iDATA = 8'h00;
        bus1.iStart = 1'b0; bus1.iRS = 1'b0; bus1.iDATA = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(en_w), 32'd0);
        chk("rst_done", 32'(done_w), 32'd0);
        chk("rst_rs", 32'(rs_w), 32'd0);
        chk("rst_rw", 32'(rw_w), 32'd0);
        chk("rst_data", 32'(data_w[0]), 32'd0);
        chk("rst_state", 32'(st_w[0]), 32'(IDLE));
        rst_n = 1'b1;
        while (cyc < 9) @(negedge clk);

        // Single command 0x38
        do_xfer(0, 1'b0, 8'h38);
        chk("cmd_pulses", 32'(pulses[0]), 32'd1);
        chk("cmd_dones", 32'(done_cnt[0]), 32'd1);
        chk("cmd_hold_data", 32'(data_w[0]), 32'h38);

        // Data write 0x157, no re-trigger after iStart drops
        p0 = pulses[0]; d0 = done_cnt[0];
        do_xfer(0, 1'b1, 8'h57);
        repeat (30) @(negedge clk);
        chk("data_pulses", 32'(pulses[0] - p0), 32'd1);
        chk("data_dones", 32'(done_cnt[0] - d0), 32'd1);
        chk("data_state_idle", 32'(st_w[0]), 32'(IDLE));

        // Init sequence plus 32 characters back to back
        p0 = pulses[0];
        for (int i = 0; i < 5; i++) do_xfer(0, 1'b0, init_seq[i]);
        for (int i = 0; i < 32; i++) do_xfer(0, 1'b1, 8'($urandom_range(8'h20, 8'h7E)));
        chk("b2b_pulses", 32'(pulses[0] - p0), 32'd37);

        // iStart glitch during ENABLE
        p0 = pulses[0]; d0 = done_cnt[0];
        start_xfer(0, 1'b0, CLEAR);
        wait_en(0, ok);
        chk("glitch_en_seen", 32'(ok), 32'd1);
        set_start(0, 1'b0); @(negedge clk);
        set_start(0, 1'b1); @(negedge clk);
        set_start(0, 1'b0); @(negedge clk);
        set_start(0, 1'b1);
        finish_xfer(0);
        repeat (30) @(negedge clk);
        chk("glitch_pulses", 32'(pulses[0] - p0), 32'd1);
        chk("glitch_dones", 32'(done_cnt[0] - d0), 32'd1);

        // Reset in the middle of ENABLE
        d0 = done_cnt[0];
        start_xfer(0, 1'b1, 8'h41);
        wait_en(0, ok);
        chk("rst_en_seen", 32'(ok), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_en_async", 32'(en_w[0]), 32'd0);
        set_start(0, 1'b0);
        repeat (4) @(negedge clk);
        chk("rst_mid_state", 32'(st_w[0]), 32'(IDLE));
        chk("rst_mid_data", 32'(data_w[0]), 32'd0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
        do_xfer(0, 1'b0, DDRAM_LINE2);

        // Minimum-timing instance
        p0 = pulses[1]; d0 = done_cnt[1];
        do_xfer(1, 1'b0, DISP_ON);
        do_xfer(1, 1'b1, 8'hA5);
        do_xfer(1, 1'b0, ENTRY_INC);
        repeat (5) @(negedge clk);
        chk("fast_pulses", 32'(pulses[1] - p0), 32'd3);
        chk("fast_dones", 32'(done_cnt[1] - d0), 32'd3);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("rw_low", 32'(rw_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
